uart_bus_responder: RTL and testbench
=====================================

Name: uart_bus_responder

Overview:
- Register-bus responder of the UART component: it answers the active-low cs/rd/wr/addr byte bus driven by the top-level sequencer.
- Owns the control/status register, an RX byte FIFO fed by the bit deserializer, and the TX holding register handed to the bit serializer.
- Generates the level interrupt and its interrupt id.
- Sits between the system-side bus initiator and the UART rx/tx bit engines.

Parameters:
- RX_DEPTH, 4, RX FIFO depth in bytes; must be a power of 2, at least 2.
- RX_AW, 2, RX FIFO address width; equals log2(RX_DEPTH).

Ports:
- clock  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  chip select, active low.
- rd  in  1  read strobe, active low.
- wr  in  1  write strobe, active low.
- addr  in  3  register address.
- in_data  in  8  write data from the initiator.
- out_data  out  8  registered read data to the initiator.
- irq  out  1  registered level interrupt, active high.
- irq_id  out  3  registered interrupt cause.
- rx_data  in  8  byte from the deserializer.
- rx_valid  in  1  one-cycle pulse: rx_data is valid.
- tx_data  out  8  byte to the serializer.
- tx_valid  out  1  TX byte offered to the serializer.
- tx_ready  in  1  serializer can accept a byte.

Behaviour:
- Reset, asynchronous active-high, immediate:
  - out_data=0, irq=0, irq_id=0, tx_valid=0, tx_data=0.
  - FIFO emptied (pointers and count = 0).
  - irq_rx_en=0, irq_tx_en=0, rx_overrun=0, tx_overrun=0.
  - Bus FSM to BusIdle.
  - Any access in flight is abandoned and no side effect completes.
- Bus FSM states: BusIdle, BusAccess, BusHold.
  - BusIdle -> BusAccess when cs=0 and (rd=0 or wr=0). The access is sampled on that edge.
  - BusAccess performs exactly one access, then goes to BusHold.
  - BusHold -> BusIdle when cs=1, or when rd=1 and wr=1.
  - Result: one access per strobe assertion, however long cs or the strobe is held.
  - rd=0 and wr=0 together: treated as a write only.
- Read timing: out_data is loaded on the BusAccess edge and is valid 1 cycle after the strobe is sampled. It holds until the next read.
- Register map:
  - addr 0, control/status.
    - Read bits: [0] rx_avail (FIFO not empty), [1] tx_empty (!tx_valid), [2] rx_overrun, [3] irq_rx_en, [4] irq_tx_en, [5] tx_busy (!tx_ready), [6] tx_overrun, [7]=0.
    - Write: bit3 and bit4 load the enables. Bit2 and bit6 are write-1-to-clear. Other bits are ignored.
  - addr 1, RX buffer (read only).
    - Read returns the FIFO head and pops it.
    - If the FIFO is empty: returns 0x00, no pop, no error.
    - Writes are ignored.
  - addr 2, TX buffer (write only).
    - Write when tx_valid=0: tx_data<=in_data, tx_valid<=1.
    - Write when tx_valid=1: data dropped, tx_overrun<=1.
    - Reads return 0x00.
  - addr 3-7: reads return 0x00, writes are ignored.
- TX handoff:
  - Transfer occurs on an edge where tx_valid=1 and tx_ready=1; tx_valid<=0 on that edge.
  - tx_data is stable while tx_valid=1.
  - A bus write to addr 2 on the same edge as a transfer is treated as tx_valid=1, so it is dropped and sets tx_overrun. This keeps the rule simple.
- RX FIFO:
  - rx_valid while not full: push.
  - rx_valid while full with no pop on the same edge: byte dropped, rx_overrun<=1, FIFO contents unchanged.
  - Pop and push on the same edge while full: both occur, count unchanged, no overrun.
  - Pop and push on the same edge while empty: the read returns 0x00 and the pushed byte is stored.
  - Pointers wrap modulo RX_DEPTH. Count range is 0..RX_DEPTH (RX_AW+1 bits).
- Interrupts, registered, updated 1 cycle after the cause changes:
  - irq = (irq_rx_en & rx_avail) | (irq_tx_en & tx_empty).
  - irq_id = 3'b001 if the RX cause is active (priority), else 3'b010 if the TX cause is active, else 3'b000.
  - rx_overrun and tx_overrun do not raise irq.
- Status clear vs set on the same edge: the set wins, so the flag stays 1.

Test Plan:
- Reset, then read addr 0 -> out_data=8'h22 (tx_empty=1, tx_busy=1 with tx_ready=0); irq=0; irq_id=0.
- tx_ready=0; write 8'h4F to addr 2, holding cs=0 for 5 cycles with wr low for 1 cycle.
  - -> tx_valid=1, tx_data=8'h4F.
  - Second write 8'h6B -> dropped; status bit6=1.
  - Raise tx_ready -> tx_valid=0 next cycle.
  - Write 8'h40 to addr 0 -> bit6 cleared.
- Write 8'h08 to addr 0; pulse rx_valid with 8'hA5.
  - -> irq=1, irq_id=3'b001 two cycles after the pulse.
  - Read addr 1 -> 8'hA5; irq=0 after the FIFO empties.
- Push 5 bytes 8'h01..8'h05 with RX_DEPTH=4.
  - -> rx_overrun=1.
  - Four reads -> 01,02,03,04.
  - Fifth read -> 8'h00.
- FIFO full; rx_valid on the same edge as the addr 1 read is sampled.
  - -> no overrun, count stays 4.
  - Subsequent reads return the correct order, including the new byte last.
- Assert reset mid-BusAccess and with tx_valid=1.
  - -> tx_valid=0, FIFO empty, FSM in BusIdle.
  - A held strobe after reset release performs exactly one access.

Source files
------------

// File: rtl/uart_bus_responder.sv
// uart_bus_responder
//   Register-bus side of the UART. It answers the active-low cs/rd/wr byte
//   bus, owns the control/status register, buffers received bytes in a small
//   FIFO, holds the byte offered to the serializer, and drives the level
//   interrupt together with its cause id.
//
// Ports
//   clock, reset        system clock; asynchronous active-high reset
//   cs, rd, wr          chip select / read / write strobes, active low
//   addr, in_data       register address and write data
//   out_data            registered read data
//   irq, irq_id         registered level interrupt and cause (001 RX, 010 TX)
//   rx_data, rx_valid   byte from the deserializer, one-cycle valid pulse
//   tx_data, tx_valid   byte offered to the serializer
//   tx_ready            serializer can take a byte this cycle
module uart_bus_responder #(
  parameter int RX_DEPTH = 4,
  parameter int RX_AW    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  output logic       irq,
  output logic [2:0] irq_id,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam logic [RX_AW:0]   FULL_COUNT = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [RX_AW:0]   COUNT_ONE  = (RX_AW + 1)'(1);
  localparam logic [RX_AW-1:0] PTR_ONE    = RX_AW'(1);

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACCESS,
    BUS_HOLD
  } bus_state_t;

  bus_state_t state_reg, state_next;

  // Access latched on the strobe edge and performed one cycle later.
  logic       acc_write_reg;
  logic [2:0] acc_addr_reg;
  logic [7:0] acc_wdata_reg;

  logic       irq_rx_en_reg, irq_tx_en_reg;
  logic       rx_overrun_reg, tx_overrun_reg;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [RX_AW:0]   count_reg;

  logic strobe, capture, access;
  logic wr_ctrl, wr_tx, rd_ctrl, rd_rx;
  logic rx_avail, rx_full, pop, push, rx_drop;
  logic [7:0] status;

  // rd and wr low together count as a write.
  assign strobe = !cs && (!rd || !wr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= BUS_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    access     = 1'b0;
    case (state_reg)
      BUS_IDLE: begin
        if (strobe) begin
          capture    = 1'b1;
          state_next = BUS_ACCESS;
        end
      end
      BUS_ACCESS: begin
        access     = 1'b1;
        state_next = BUS_HOLD;
      end
      BUS_HOLD: begin
        // Stay here until the strobe goes away so a long strobe is one access.
        if (cs || (rd && wr)) state_next = BUS_IDLE;
      end
      default: state_next = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_write_reg <= 1'b0;
      acc_addr_reg  <= 3'd0;
      acc_wdata_reg <= 8'd0;
    end else if (capture) begin
      acc_write_reg <= !wr;
      acc_addr_reg  <= addr;
      acc_wdata_reg <= in_data;
    end
  end

  assign wr_ctrl = access &&  acc_write_reg && (acc_addr_reg == 3'd0);
  assign wr_tx   = access &&  acc_write_reg && (acc_addr_reg == 3'd2);
  assign rd_ctrl = access && !acc_write_reg && (acc_addr_reg == 3'd0);
  assign rd_rx   = access && !acc_write_reg && (acc_addr_reg == 3'd1);

  assign rx_avail = (count_reg != '0);
  assign rx_full  = (count_reg == FULL_COUNT);
  assign pop      = rd_rx && rx_avail;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push     = rx_valid && (!rx_full || pop);
  assign rx_drop  = rx_valid && rx_full && !pop;

  assign status = {1'b0, tx_overrun_reg, !tx_ready, irq_tx_en_reg,
                   irq_rx_en_reg, rx_overrun_reg, !tx_valid, rx_avail};

  // FIFO storage: no reset so it maps onto plain RAM. When full with a
  // simultaneous pop, wr_ptr equals rd_ptr; the pop reads the old byte on
  // this edge before the new one lands.
  always_ff @(posedge clock) begin
    if (push) rx_mem[wr_ptr_reg] <= rx_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data <= 8'd0;
    end else if (access && !acc_write_reg) begin
      if (rd_ctrl)  out_data <= status;
      else if (pop) out_data <= rx_mem[rd_ptr_reg];
      else          out_data <= 8'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_rx_en_reg  <= 1'b0;
      irq_tx_en_reg  <= 1'b0;
      rx_overrun_reg <= 1'b0;
      tx_overrun_reg <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_rx_en_reg <= acc_wdata_reg[3];
        irq_tx_en_reg <= acc_wdata_reg[4];
      end
      // Set beats write-1-to-clear on the same edge.
      if (rx_drop)                            rx_overrun_reg <= 1'b1;
      else if (wr_ctrl && acc_wdata_reg[2])   rx_overrun_reg <= 1'b0;
      if (wr_tx && tx_valid)                  tx_overrun_reg <= 1'b1;
      else if (wr_ctrl && acc_wdata_reg[6])   tx_overrun_reg <= 1'b0;
    end
  end

  // A write landing on the handoff edge still sees tx_valid=1 and is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
    end else if (wr_tx && !tx_valid) begin
      tx_valid <= 1'b1;
      tx_data  <= acc_wdata_reg;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq    <= 1'b0;
      irq_id <= 3'b000;
    end else begin
      irq <= (irq_rx_en_reg && rx_avail) || (irq_tx_en_reg && !tx_valid);
      if (irq_rx_en_reg && rx_avail)       irq_id <= 3'b001;
      else if (irq_tx_en_reg && !tx_valid) irq_id <= 3'b010;
      else                                 irq_id <= 3'b000;
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
module tb_uart_bus_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       cs, rd, wr;
  logic [2:0] addr;
  logic [7:0] in_data;
  logic [7:0] out_data;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int n_checks = 0;
  int n_pass   = 0;

  uart_bus_responder #(.RX_DEPTH(4), .RX_AW(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .cs       (cs),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .in_data  (in_data),
    .out_data (out_data),
    .irq      (irq),
    .irq_id   (irq_id),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;      // 0 read, 1 write, 2 rx push
    logic [2:0] a;
    logic [7:0] d;
    logic       chk_data;
    logic [7:0] exp_data;
    logic       exp_irq;
    logic [2:0] exp_id;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s: got %02h", name, act);
    end else begin
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Strobe sampled at first edge, access on second, hold released on third.
  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b0; rd = 1'b0; addr = a;
    tick();
    tick();
    d = out_data;
    cs = 1'b1; rd = 1'b1;
    tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b0; wr = 1'b0; addr = a; in_data = d;
    tick();
    tick();
    cs = 1'b1; wr = 1'b1;
    tick();
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] rdata;
    logic [7:0] exp_b;

    vecs[0]  = '{1, 3'd0, 8'h08, 1'b0, 8'h00, 1'b0, 3'b000};
    vecs[1]  = '{2, 3'd0, 8'hA5, 1'b0, 8'h00, 1'b1, 3'b001};
    vecs[2]  = '{0, 3'd0, 8'h00, 1'b1, 8'h0B, 1'b1, 3'b001};
    vecs[3]  = '{0, 3'd1, 8'h00, 1'b1, 8'hA5, 1'b0, 3'b000};
    vecs[4]  = '{0, 3'd1, 8'h00, 1'b1, 8'h00, 1'b0, 3'b000};
    vecs[5]  = '{1, 3'd0, 8'h18, 1'b0, 8'h00, 1'b1, 3'b010};
    vecs[6]  = '{2, 3'd0, 8'h3C, 1'b0, 8'h00, 1'b1, 3'b001};
    vecs[7]  = '{0, 3'd5, 8'h00, 1'b1, 8'h00, 1'b1, 3'b001};
    vecs[8]  = '{1, 3'd1, 8'h77, 1'b0, 8'h00, 1'b1, 3'b001};
    vecs[9]  = '{0, 3'd2, 8'h00, 1'b1, 8'h00, 1'b1, 3'b001};
    vecs[10] = '{0, 3'd1, 8'h00, 1'b1, 8'h3C, 1'b1, 3'b010};
    vecs[11] = '{1, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'b000};

    reset = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 3'd0; in_data = 8'h00;
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("reset out_data", out_data, 8'h00);
    check("reset irq", {7'd0, irq}, 8'h00);
    check("reset irq_id", {5'd0, irq_id}, 8'h00);
    check("reset tx_valid", {7'd0, tx_valid}, 8'h00);
    check("reset tx_data", tx_data, 8'h00);

    bus_read(3'd0, rdata);
    check("status after reset", rdata, 8'h22);
    check("irq after reset", {7'd0, irq}, 8'h00);

    // TX: cs held low 5 cycles, wr low for one.
    cs = 1'b0; wr = 1'b0; addr = 3'd2; in_data = 8'h4F;
    tick();
    wr = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    cs = 1'b1;
    tick();
    check("tx_valid after write", {7'd0, tx_valid}, 8'h01);
    check("tx_data after write", tx_data, 8'h4F);
    bus_write(3'd2, 8'h6B);
    check("tx_data kept on overrun", tx_data, 8'h4F);
    bus_read(3'd0, rdata);
    check("status tx_overrun", rdata, 8'h60);
    tx_ready = 1'b1;
    tick();
    check("tx_valid after handoff", {7'd0, tx_valid}, 8'h00);
    bus_write(3'd0, 8'h40);
    bus_read(3'd0, rdata);
    check("status tx_overrun cleared", rdata, 8'h02);

    // Table of bus ops and RX pushes with expected read data and interrupt.
    for (int i = 0; i < 12; i++) begin
      case (vecs[i].kind)
        0:       bus_read(vecs[i].a, rdata);
        1:       bus_write(vecs[i].a, vecs[i].d);
        default: rx_push(vecs[i].d);
      endcase
      if (vecs[i].chk_data) check($sformatf("vec%0d data", i), rdata, vecs[i].exp_data);
      check($sformatf("vec%0d irq", i), {7'd0, irq}, {7'd0, vecs[i].exp_irq});
      check($sformatf("vec%0d irq_id", i), {5'd0, irq_id}, {5'd0, vecs[i].exp_id});
    end

    // Overfill a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) rx_push(8'(i));
    bus_read(3'd0, rdata);
    check("status rx_overrun", rdata, 8'h07);
    for (int i = 1; i <= 4; i++) begin
      bus_read(3'd1, rdata);
      exp_b = 8'(i);
      check($sformatf("fifo read %0d", i), rdata, exp_b);
    end
    bus_read(3'd1, rdata);
    check("fifo read empty", rdata, 8'h00);
    bus_write(3'd0, 8'h04);
    bus_read(3'd0, rdata);
    check("status rx_overrun cleared", rdata, 8'h02);

    // Full FIFO, push on the same edge the pop is performed.
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33); rx_push(8'h44);
    cs = 1'b0; rd = 1'b0; addr = 3'd1;
    tick();
    rx_valid = 1'b1; rx_data = 8'h55;
    tick();
    rx_valid = 1'b0;
    rdata = out_data;
    cs = 1'b1; rd = 1'b1;
    tick();
    check("full pop+push data", rdata, 8'h11);
    bus_read(3'd0, rdata);
    check("full pop+push no overrun", rdata, 8'h03);
    bus_read(3'd1, rdata); check("order 22", rdata, 8'h22);
    bus_read(3'd1, rdata); check("order 33", rdata, 8'h33);
    bus_read(3'd1, rdata); check("order 44", rdata, 8'h44);
    bus_read(3'd1, rdata); check("order 55", rdata, 8'h55);
    bus_read(3'd1, rdata); check("order empty", rdata, 8'h00);

    // Reset mid-access with a TX byte pending.
    tx_ready = 1'b0;
    bus_write(3'd2, 8'hE1);
    check("tx pending before reset", {7'd0, tx_valid}, 8'h01);
    rx_push(8'h66);
    cs = 1'b0; rd = 1'b0; addr = 3'd1;
    tick();
    reset = 1'b1;
    #1;
    check("reset tx_valid mid-access", {7'd0, tx_valid}, 8'h00);
    check("reset tx_data mid-access", tx_data, 8'h00);
    check("reset out_data mid-access", out_data, 8'h00);
    rd = 1'b1; wr = 1'b0; addr = 3'd2; in_data = 8'h5A;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    cs = 1'b1; wr = 1'b1;
    tick();
    check("held strobe tx_valid", {7'd0, tx_valid}, 8'h01);
    check("held strobe tx_data", tx_data, 8'h5A);
    bus_read(3'd0, rdata);
    check("held strobe single access", rdata, 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
